// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: access-size codes, datapath widths and the MEM/WB record.
package mem_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam logic [1:0] ACC_WORD = 2'b00;
    localparam logic [1:0] ACC_HALF = 2'b01;
    localparam logic [1:0] ACC_BYTE = 2'b10;

    typedef struct packed {
        logic              effective;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] ir;
        logic [DATA_W-1:0] r1_data;
        logic [DATA_W-1:0] r2_data;
        logic [REG_W-1:0]  rd_no;
        logic              regwrite;
        logic              syscall;
        logic              jal;
        logic [DATA_W-1:0] rd_data;
    } mem_wb_t;

endpackage

// File: rtl/mem_stage_if.sv
// Bundle of EX/MEM inputs, data-RAM port and MEM/WB outputs around the MEM stage.
interface mem_stage_if
    import mem_stage_pkg::*;
#(
    parameter int ADDR_BITS = 12
);
    logic                 stall;
    logic                 flush;
    logic                 mem_effective;
    logic [DATA_W-1:0]    mem_pc;
    logic [DATA_W-1:0]    mem_ir;
    logic [DATA_W-1:0]    mem_alu_result;
    logic [DATA_W-1:0]    mem_r1_data;
    logic [DATA_W-1:0]    mem_r2_data;
    logic [REG_W-1:0]     mem_rd_no;
    logic                 mem_regwrite;
    logic                 mem_memtoreg;
    logic                 mem_memwrite;
    logic                 mem_syscall;
    logic                 mem_jal;
    logic [1:0]           mem_access;
    logic                 mem_extend;
    logic [DATA_W-1:0]    ram_data_out;
    logic [ADDR_BITS-3:0] ram_addr;
    logic [DATA_W-1:0]    ram_data_in;
    logic [3:0]           ram_sel;
    logic                 ram_rw;
    logic [DATA_W-1:0]    mem_redirect;
    logic                 wb_effective;
    logic [DATA_W-1:0]    wb_pc;
    logic [DATA_W-1:0]    wb_ir;
    logic [DATA_W-1:0]    wb_r1_data;
    logic [DATA_W-1:0]    wb_r2_data;
    logic [REG_W-1:0]     wb_rd_no;
    logic                 wb_regwrite;
    logic                 wb_syscall;
    logic                 wb_jal;
    logic [DATA_W-1:0]    wb_rd_data;
    logic [DATA_W-1:0]    load_num;
    logic [DATA_W-1:0]    store_num;
    logic                 misalign;

    modport master (
        output stall, flush, mem_effective, mem_pc, mem_ir, mem_alu_result,
               mem_r1_data, mem_r2_data, mem_rd_no, mem_regwrite, mem_memtoreg,
               mem_memwrite, mem_syscall, mem_jal, mem_access, mem_extend, ram_data_out,
        input  ram_addr, ram_data_in, ram_sel, ram_rw, mem_redirect, wb_effective,
               wb_pc, wb_ir, wb_r1_data, wb_r2_data, wb_rd_no, wb_regwrite,
               wb_syscall, wb_jal, wb_rd_data, load_num, store_num, misalign
    );

    modport slave (
        input  stall, flush, mem_effective, mem_pc, mem_ir, mem_alu_result,
               mem_r1_data, mem_r2_data, mem_rd_no, mem_regwrite, mem_memtoreg,
               mem_memwrite, mem_syscall, mem_jal, mem_access, mem_extend, ram_data_out,
        output ram_addr, ram_data_in, ram_sel, ram_rw, mem_redirect, wb_effective,
               wb_pc, wb_ir, wb_r1_data, wb_r2_data, wb_rd_no, wb_regwrite,
               wb_syscall, wb_jal, wb_rd_data, load_num, store_num, misalign
    );

endinterface

// File: rtl/mem_stage_align.sv
// Byte-lane steering: store enables/replication and load extraction with zero/sign extension.
// MEM_MISALIGN_TRAP_EN: flag misaligned half/word addresses; undefined, the flag is tied 0.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]        addr_lo_i,
    input  logic [1:0]        access_i,
    input  logic              extend_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic [3:0]        sel_o,
    output logic [DATA_W-1:0] store_lanes_o,
    output logic [DATA_W-1:0] load_data_o,
    output logic              misaligned_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // The reserved access code behaves as a word access.
    always_comb begin
        sel_o         = 4'b1111;
        store_lanes_o = store_data_i;
        case (access_i)
            ACC_BYTE: begin
                sel_o         = 4'b0001 << addr_lo_i;
                store_lanes_o = {4{store_data_i[7:0]}};
            end
            ACC_HALF: begin
                sel_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                store_lanes_o = {2{store_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_v = ram_rdata_i[7:0];
        case (addr_lo_i)
            2'd1:    byte_v = ram_rdata_i[15:8];
            2'd2:    byte_v = ram_rdata_i[23:16];
            2'd3:    byte_v = ram_rdata_i[31:24];
            default: ;
        endcase
        half_v = addr_lo_i[1] ? ram_rdata_i[31:16] : ram_rdata_i[15:0];
        case (access_i)
            ACC_BYTE: load_data_o = {{24{extend_i & byte_v[7]}}, byte_v};
            ACC_HALF: load_data_o = {{16{extend_i & half_v[15]}}, half_v};
            default:  load_data_o = ram_rdata_i;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        misaligned_o = 1'b0;
        case (access_i)
            ACC_BYTE: misaligned_o = 1'b0;
            ACC_HALF: misaligned_o = addr_lo_i[0];
            default:  misaligned_o = |addr_lo_i;
        endcase
    end
`else
    assign misaligned_o = 1'b0;
`endif

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-RAM access generation, MEM/WB pipeline register and load/store counters.
// Misalignment trapping follows MEM_MISALIGN_TRAP_EN inside mem_align.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_BITS = 12
)
(
    input  logic        clk,
    input  logic        rst_n,
    mem_stage_if.slave  bus
);

    logic [3:0]        sel;
    logic [DATA_W-1:0] store_lanes;
    logic [DATA_W-1:0] load_data;
    logic              misaligned;
    logic              bad_access;
    logic              commit;
    mem_wb_t           wb_q, wb_d;
    logic [DATA_W-1:0] load_num_q, load_num_d;
    logic [DATA_W-1:0] store_num_q, store_num_d;
    logic              misalign_q, misalign_d;

    mem_align u_align (
        .addr_lo_i     (bus.mem_alu_result[1:0]),
        .access_i      (bus.mem_access),
        .extend_i      (bus.mem_extend),
        .store_data_i  (bus.mem_r2_data),
        .ram_rdata_i   (bus.ram_data_out),
        .sel_o         (sel),
        .store_lanes_o (store_lanes),
        .load_data_o   (load_data),
        .misaligned_o  (misaligned)
    );

    // Only real memory operations can be misaligned; ALU results are arbitrary values.
    assign bad_access = (bus.mem_memtoreg | bus.mem_memwrite) & misaligned;
    assign commit     = bus.mem_effective & ~bus.stall & ~bus.flush;

    assign bus.ram_addr     = bus.mem_alu_result[ADDR_BITS-1:2];
    assign bus.ram_data_in  = store_lanes;
    assign bus.ram_sel      = bad_access ? 4'b0000 : sel;
    assign bus.ram_rw       = commit & bus.mem_memwrite & ~bad_access;
    assign bus.mem_redirect = bus.mem_alu_result;

    always_comb begin
        wb_d        = wb_q;
        load_num_d  = load_num_q + {{(DATA_W-1){1'b0}}, commit & bus.mem_memtoreg & ~bad_access};
        store_num_d = store_num_q + {{(DATA_W-1){1'b0}}, commit & bus.mem_memwrite & ~bad_access};
        misalign_d  = misalign_q | (commit & bad_access);
        if (bus.flush) begin
            wb_d = '0;
        end else if (!bus.stall) begin
            wb_d.effective = bus.mem_effective;
            wb_d.pc        = bus.mem_pc;
            wb_d.ir        = bus.mem_ir;
            wb_d.r1_data   = bus.mem_r1_data;
            wb_d.r2_data   = bus.mem_r2_data;
            wb_d.rd_no     = bus.mem_rd_no;
            wb_d.regwrite  = bus.mem_regwrite & ~bad_access;
            wb_d.syscall   = bus.mem_syscall;
            wb_d.jal       = bus.mem_jal;
            wb_d.rd_data   = bus.mem_memtoreg ? load_data : bus.mem_alu_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q        <= '0;
            load_num_q  <= '0;
            store_num_q <= '0;
            misalign_q  <= 1'b0;
        end else begin
            wb_q        <= wb_d;
            load_num_q  <= load_num_d;
            store_num_q <= store_num_d;
            misalign_q  <= misalign_d;
        end
    end

    assign bus.wb_effective = wb_q.effective;
    assign bus.wb_pc        = wb_q.pc;
    assign bus.wb_ir        = wb_q.ir;
    assign bus.wb_r1_data   = wb_q.r1_data;
    assign bus.wb_r2_data   = wb_q.r2_data;
    assign bus.wb_rd_no     = wb_q.rd_no;
    assign bus.wb_regwrite  = wb_q.regwrite;
    assign bus.wb_syscall   = wb_q.syscall;
    assign bus.wb_jal       = wb_q.jal;
    assign bus.wb_rd_data   = wb_q.rd_data;
    assign bus.load_num     = load_num_q;
    assign bus.store_num    = store_num_q;
    assign bus.misalign     = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus randomized ops against a behavioural model.
// Expectations for the misaligned-store case follow MEM_MISALIGN_TRAP_EN.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   exp_loads;
    int   exp_stores;

    mem_stage_if #(.ADDR_BITS(12)) bus ();

    mem_stage #(.ADDR_BITS(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Step to just after the next rising edge so registered outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 = ALU op, 1 = load, 2 = store
    task automatic drive_op(input logic eff, input int kind, input logic [1:0] acc,
                            input logic ext, input logic [31:0] a, input logic [31:0] r2,
                            input logic [31:0] rdata, input logic [31:0] pc,
                            input logic stl, input logic fl);
        bus.mem_effective  = eff;
        bus.mem_memtoreg   = (kind == 1);
        bus.mem_memwrite   = (kind == 2);
        bus.mem_regwrite   = (kind != 2);
        bus.mem_access     = acc;
        bus.mem_extend     = ext;
        bus.mem_alu_result = a;
        bus.mem_r2_data    = r2;
        bus.mem_r1_data    = ~r2;
        bus.ram_data_out   = rdata;
        bus.mem_pc         = pc;
        bus.mem_ir         = pc ^ 32'h1234_5678;
        bus.mem_rd_no      = pc[6:2];
        bus.mem_syscall    = 1'b0;
        bus.mem_jal        = 1'b0;
        bus.stall          = stl;
        bus.flush          = fl;
    endtask

    task automatic set_idle();
        drive_op(1'b0, 0, ACC_WORD, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] model_load(input logic [1:0] acc, input int unsigned a,
                                               input logic ext, input logic [31:0] ram);
        int unsigned w;
        int unsigned shift;
        logic [31:0] v;
        if (acc == ACC_BYTE) begin
            w = 8;
            shift = 8 * (a % 4);
        end else if (acc == ACC_HALF) begin
            w = 16;
            shift = 16 * ((a / 2) % 2);
        end else begin
            return ram;
        end
        v = (ram >> shift) & ((32'h1 << w) - 32'h1);
        if (ext && v >= (32'h1 << (w - 1))) v = v - (32'h1 << w);
        return v;
    endfunction

    function automatic logic [3:0] model_sel(input logic [1:0] acc, input int unsigned a);
        if (acc == ACC_BYTE) return 4'(1 << (a % 4));
        if (acc == ACC_HALF) return ((a % 4) >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_lanes(input logic [1:0] acc, input logic [31:0] d);
        if (acc == ACC_BYTE) return (d & 32'hFF) * 32'h0101_0101;
        if (acc == ACC_HALF) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic model_mis(input int kind, input logic [1:0] acc, input int unsigned a);
`ifdef MEM_MISALIGN_TRAP_EN
        if (kind == 0) return 1'b0;
        if (acc == ACC_BYTE) return 1'b0;
        if (acc == ACC_HALF) return (a % 2) != 0;
        return (a % 4) != 0;
`else
        return (kind < 0) && (acc == ACC_BYTE) && (a == 0);
`endif
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        #12;
        n_checks++; if (bus.wb_effective !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_wb_eff got %b want 0", bus.wb_effective); end
        n_checks++; if (bus.wb_rd_data !== 32'h0) begin n_errors++; $display("[TB] FAIL reset_wb_rd got %h want 0", bus.wb_rd_data); end
        n_checks++; if (bus.load_num !== 32'h0) begin n_errors++; $display("[TB] FAIL reset_loads got %0d want 0", bus.load_num); end
        n_checks++; if (bus.store_num !== 32'h0) begin n_errors++; $display("[TB] FAIL reset_stores got %0d want 0", bus.store_num); end
        n_checks++; if (bus.misalign !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_misalign got %b want 0", bus.misalign); end
        rst_n = 1'b1;
        exp_loads = 0;
        exp_stores = 0;
        tick();
    endtask

    task automatic test_store_byte();
        drive_op(1'b1, 2, ACC_BYTE, 1'b0, 32'h006, 32'h1234_56A5, 32'h0, 32'h100, 1'b0, 1'b0);
        #2;
        n_checks++; if (bus.ram_sel !== 4'b0100) begin n_errors++; $display("[TB] FAIL sb_sel got %b want 0100", bus.ram_sel); end
        n_checks++; if (bus.ram_data_in !== 32'hA5A5A5A5) begin n_errors++; $display("[TB] FAIL sb_data got %h want A5A5A5A5", bus.ram_data_in); end
        n_checks++; if (bus.ram_rw !== 1'b1) begin n_errors++; $display("[TB] FAIL sb_rw got %b want 1", bus.ram_rw); end
        n_checks++; if (bus.ram_addr !== 10'h001) begin n_errors++; $display("[TB] FAIL sb_addr got %h want 001", bus.ram_addr); end
        tick();
        exp_stores++;
        n_checks++; if (bus.store_num !== 32'(exp_stores)) begin n_errors++; $display("[TB] FAIL sb_count got %0d want %0d", bus.store_num, exp_stores); end
    endtask

    task automatic test_load_byte();
        drive_op(1'b1, 1, ACC_BYTE, 1'b1, 32'h003, 32'h0, 32'h80FF7F01, 32'h104, 1'b0, 1'b0);
        tick();
        exp_loads++;
        n_checks++; if (bus.wb_rd_data !== 32'hFFFFFF80) begin n_errors++; $display("[TB] FAIL lb_sign got %h want FFFFFF80", bus.wb_rd_data); end
        n_checks++; if (bus.load_num !== 32'(exp_loads)) begin n_errors++; $display("[TB] FAIL lb_count got %0d want %0d", bus.load_num, exp_loads); end
        drive_op(1'b1, 1, ACC_BYTE, 1'b0, 32'h003, 32'h0, 32'h80FF7F01, 32'h108, 1'b0, 1'b0);
        tick();
        exp_loads++;
        n_checks++; if (bus.wb_rd_data !== 32'h00000080) begin n_errors++; $display("[TB] FAIL lb_zero got %h want 00000080", bus.wb_rd_data); end
        n_checks++; if (bus.wb_regwrite !== 1'b1) begin n_errors++; $display("[TB] FAIL lb_regwrite got %b want 1", bus.wb_regwrite); end
    endtask

    task automatic test_load_half();
        drive_op(1'b1, 1, ACC_HALF, 1'b1, 32'h002, 32'h0, 32'h80011234, 32'h10C, 1'b0, 1'b0);
        tick();
        exp_loads++;
        n_checks++; if (bus.wb_rd_data !== 32'hFFFF8001) begin n_errors++; $display("[TB] FAIL lh_hi got %h want FFFF8001", bus.wb_rd_data); end
        drive_op(1'b1, 1, ACC_HALF, 1'b1, 32'h000, 32'h0, 32'h80011234, 32'h110, 1'b0, 1'b0);
        tick();
        exp_loads++;
        n_checks++; if (bus.wb_rd_data !== 32'h00001234) begin n_errors++; $display("[TB] FAIL lh_lo got %h want 00001234", bus.wb_rd_data); end
        n_checks++; if (bus.load_num !== 32'(exp_loads)) begin n_errors++; $display("[TB] FAIL lh_count got %0d want %0d", bus.load_num, exp_loads); end
    endtask

    task automatic test_stall();
        drive_op(1'b1, 2, ACC_WORD, 1'b0, 32'h020, 32'hDEADBEEF, 32'h0, 32'h114, 1'b1, 1'b0);
        for (int c = 0; c < 2; c++) begin
            #2;
            n_checks++; if (bus.ram_rw !== 1'b0) begin n_errors++; $display("[TB] FAIL stall_rw got %b want 0", bus.ram_rw); end
            tick();
            n_checks++; if (bus.wb_pc !== 32'h110) begin n_errors++; $display("[TB] FAIL stall_wb_pc got %h want 110", bus.wb_pc); end
            n_checks++; if (bus.wb_rd_data !== 32'h00001234) begin n_errors++; $display("[TB] FAIL stall_wb_rd got %h want 00001234", bus.wb_rd_data); end
            n_checks++; if (bus.store_num !== 32'(exp_stores)) begin n_errors++; $display("[TB] FAIL stall_count got %0d want %0d", bus.store_num, exp_stores); end
        end
        bus.stall = 1'b0;
        #2;
        n_checks++; if (bus.ram_rw !== 1'b1) begin n_errors++; $display("[TB] FAIL unstall_rw got %b want 1", bus.ram_rw); end
        tick();
        exp_stores++;
        n_checks++; if (bus.store_num !== 32'(exp_stores)) begin n_errors++; $display("[TB] FAIL unstall_count got %0d want %0d", bus.store_num, exp_stores); end
        n_checks++; if (bus.wb_pc !== 32'h114) begin n_errors++; $display("[TB] FAIL unstall_wb_pc got %h want 114", bus.wb_pc); end
    endtask

    task automatic test_flush_stall();
        drive_op(1'b1, 1, ACC_WORD, 1'b0, 32'h040, 32'h0, 32'h55AA55AA, 32'h118, 1'b1, 1'b1);
        tick();
        n_checks++; if (bus.wb_effective !== 1'b0) begin n_errors++; $display("[TB] FAIL flush_eff got %b want 0", bus.wb_effective); end
        n_checks++; if (bus.wb_regwrite !== 1'b0) begin n_errors++; $display("[TB] FAIL flush_regwrite got %b want 0", bus.wb_regwrite); end
        n_checks++; if (bus.wb_pc !== 32'h0) begin n_errors++; $display("[TB] FAIL flush_pc got %h want 0", bus.wb_pc); end
        n_checks++; if (bus.load_num !== 32'(exp_loads)) begin n_errors++; $display("[TB] FAIL flush_count got %0d want %0d", bus.load_num, exp_loads); end
    endtask

    task automatic test_async_reset();
        drive_op(1'b1, 1, ACC_WORD, 1'b0, 32'h044, 32'h0, 32'h0BADF00D, 32'h11C, 1'b0, 1'b0);
        tick();
        n_checks++; if (bus.wb_rd_data !== 32'h0BADF00D) begin n_errors++; $display("[TB] FAIL pre_rst_rd got %h want 0BADF00D", bus.wb_rd_data); end
        set_idle();
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.wb_effective !== 1'b0) begin n_errors++; $display("[TB] FAIL arst_eff got %b want 0", bus.wb_effective); end
        n_checks++; if (bus.wb_rd_data !== 32'h0) begin n_errors++; $display("[TB] FAIL arst_rd got %h want 0", bus.wb_rd_data); end
        n_checks++; if (bus.load_num !== 32'h0) begin n_errors++; $display("[TB] FAIL arst_loads got %0d want 0", bus.load_num); end
        n_checks++; if (bus.store_num !== 32'h0) begin n_errors++; $display("[TB] FAIL arst_stores got %0d want 0", bus.store_num); end
        #2 rst_n = 1'b1;
        exp_loads = 0;
        exp_stores = 0;
        tick();
    endtask

    task automatic test_misalign();
        drive_op(1'b1, 2, ACC_WORD, 1'b0, 32'h005, 32'hCAFEF00D, 32'h0, 32'h200, 1'b0, 1'b0);
        #2;
`ifdef MEM_MISALIGN_TRAP_EN
        n_checks++; if (bus.ram_rw !== 1'b0) begin n_errors++; $display("[TB] FAIL mis_rw got %b want 0", bus.ram_rw); end
        n_checks++; if (bus.ram_sel !== 4'b0000) begin n_errors++; $display("[TB] FAIL mis_sel got %b want 0000", bus.ram_sel); end
        tick();
        n_checks++; if (bus.misalign !== 1'b1) begin n_errors++; $display("[TB] FAIL mis_flag got %b want 1", bus.misalign); end
        set_idle();
        tick();
        n_checks++; if (bus.misalign !== 1'b1) begin n_errors++; $display("[TB] FAIL mis_sticky got %b want 1", bus.misalign); end
`else
        n_checks++; if (bus.ram_rw !== 1'b1) begin n_errors++; $display("[TB] FAIL mis_rw got %b want 1", bus.ram_rw); end
        n_checks++; if (bus.ram_sel !== 4'b1111) begin n_errors++; $display("[TB] FAIL mis_sel got %b want 1111", bus.ram_sel); end
        n_checks++; if (bus.ram_addr !== 10'h001) begin n_errors++; $display("[TB] FAIL mis_addr got %h want 001", bus.ram_addr); end
        tick();
        exp_stores++;
        n_checks++; if (bus.misalign !== 1'b0) begin n_errors++; $display("[TB] FAIL mis_flag got %b want 0", bus.misalign); end
`endif
        n_checks++; if (bus.store_num !== 32'(exp_stores)) begin n_errors++; $display("[TB] FAIL mis_count got %0d want %0d", bus.store_num, exp_stores); end
    endtask

    task automatic test_random();
        logic        m_eff, m_regw, m_mis_flag, eff, ext, stl, fl, commit, mis;
        logic [31:0] m_pc, m_rd, a, r2, rdata, pc;
        logic [1:0]  acc;
        int          kind;
        int unsigned m_loads, m_stores;
        set_idle();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        m_eff = 0; m_regw = 0; m_mis_flag = 0; m_pc = 0; m_rd = 0; m_loads = 0; m_stores = 0;
        for (int i = 0; i < 200; i++) begin
            eff   = ($urandom_range(0, 9) != 0);
            kind  = int'($urandom_range(0, 2));
            acc   = 2'($urandom_range(0, 3));
            ext   = 1'($urandom_range(0, 1));
            a     = $urandom & 32'hFFF;
            r2    = $urandom;
            rdata = $urandom;
            pc    = $urandom & 32'hFFFC;
            stl   = ($urandom_range(0, 5) == 0);
            fl    = ($urandom_range(0, 7) == 0);
            drive_op(eff, kind, acc, ext, a, r2, rdata, pc, stl, fl);
            commit = eff && !stl && !fl;
            mis    = model_mis(kind, acc, a);
            #2;
            n_checks++; if (bus.ram_rw !== (commit && kind == 2 && !mis)) begin n_errors++; $display("[TB] FAIL rnd_rw it=%0d got %b want %b", i, bus.ram_rw, commit && kind == 2 && !mis); end
            n_checks++; if (bus.ram_sel !== (mis ? 4'h0 : model_sel(acc, a))) begin n_errors++; $display("[TB] FAIL rnd_sel it=%0d got %b want %b", i, bus.ram_sel, mis ? 4'h0 : model_sel(acc, a)); end
            n_checks++; if (bus.ram_data_in !== model_lanes(acc, r2)) begin n_errors++; $display("[TB] FAIL rnd_wdata it=%0d got %h want %h", i, bus.ram_data_in, model_lanes(acc, r2)); end
            n_checks++; if (bus.ram_addr !== 10'(a / 4)) begin n_errors++; $display("[TB] FAIL rnd_addr it=%0d got %h want %h", i, bus.ram_addr, 10'(a / 4)); end
            if (fl) begin
                m_eff = 0; m_regw = 0; m_pc = 0; m_rd = 0;
            end else if (!stl) begin
                m_eff  = eff;
                m_regw = (kind != 2) && !mis;
                m_pc   = pc;
                m_rd   = (kind == 1) ? model_load(acc, a, ext, rdata) : a;
            end
            if (commit && !mis && kind == 1) m_loads++;
            if (commit && !mis && kind == 2) m_stores++;
            if (commit && mis) m_mis_flag = 1;
            tick();
            n_checks++; if (bus.wb_effective !== m_eff) begin n_errors++; $display("[TB] FAIL rnd_wb_eff it=%0d got %b want %b", i, bus.wb_effective, m_eff); end
            n_checks++; if (bus.wb_regwrite !== m_regw) begin n_errors++; $display("[TB] FAIL rnd_wb_regw it=%0d got %b want %b", i, bus.wb_regwrite, m_regw); end
            n_checks++; if (bus.wb_pc !== m_pc) begin n_errors++; $display("[TB] FAIL rnd_wb_pc it=%0d got %h want %h", i, bus.wb_pc, m_pc); end
            n_checks++; if (bus.wb_rd_data !== m_rd) begin n_errors++; $display("[TB] FAIL rnd_wb_rd it=%0d got %h want %h", i, bus.wb_rd_data, m_rd); end
            n_checks++; if (bus.load_num !== m_loads) begin n_errors++; $display("[TB] FAIL rnd_loads it=%0d got %0d want %0d", i, bus.load_num, m_loads); end
            n_checks++; if (bus.store_num !== m_stores) begin n_errors++; $display("[TB] FAIL rnd_stores it=%0d got %0d want %0d", i, bus.store_num, m_stores); end
            n_checks++; if (bus.misalign !== m_mis_flag) begin n_errors++; $display("[TB] FAIL rnd_misalign it=%0d got %b want %b", i, bus.misalign, m_mis_flag); end
        end
        set_idle();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_store_byte();
        test_load_byte();
        test_load_half();
        test_stall();
        test_flush_stall();
        test_async_reset();
        test_misalign();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
